// File: rtl/mem_pkg.sv
// mem_pkg: shared types and default widths for the memory responder, its bus
// interface and the controller/datapath that drive it.
//   state_e : responder FSM states
//   op_e    : access kind latched at capture (OP_BAD = both strobes high)
package mem_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    typedef enum logic [1:0] {
        OP_RD,
        OP_WR,
        OP_BAD
    } op_e;

endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: strobe/bus bundle between the multi-cycle controller and
// the memory responder.
//   MemRead, MemWrite : request strobes (master -> slave)
//   addr, wdata       : word address and write data (master -> slave)
//   rdata             : last completed read data (slave -> master)
//   ready, err        : one-cycle completion / illegal-request pulses (slave -> master)
//   busy              : request in flight (slave -> master)
interface mem_responder_if
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);
    logic              MemRead;
    logic              MemWrite;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic              busy;
    logic              err;

    modport master (
        output MemRead, MemWrite, addr, wdata,
        input  rdata, ready, busy, err
    );

    modport slave (
        input  MemRead, MemWrite, addr, wdata,
        output rdata, ready, busy, err
    );

endinterface

// File: rtl/mem_array.sv
// mem_array: synchronous single-port word storage, DEPTH x DATA_W, no reset.
//   clk   : clock, rising edge
//   we    : write enable (ignored for out-of-range addresses)
//   addr  : word address
//   wdata : write data
//   rdata : registered read of addr (zero for out-of-range addresses)
module mem_array
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = 200
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic              in_range;

    assign in_range = 32'(addr) < DEPTH;
    assign rdata    = rdata_q;

    always_ff @(posedge clk) begin
        if (we && in_range) begin
            mem[addr] <= wdata;
        end
        rdata_q <= in_range ? mem[addr] : '0;
    end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the controller's MemRead/MemWrite
// strobes. Captures one access in IDLE, waits LATENCY cycles, then spends one
// cycle in RESP; the array write, rdata update and ready/err pulse all land
// on the edge leaving RESP.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : mem_responder_if slave (strobes/addr/wdata in; rdata/ready/busy/err out)
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned DEPTH   = 200,
    parameter int unsigned LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);

    localparam logic [3:0] CntInit = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    logic              bad_req;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rdata;

    assign bad_req = (op_q == OP_BAD) || (32'(addr_q) >= DEPTH);
    assign ram_we  = (state_q == RESP) && (op_q == OP_WR) && !bad_req;
    // In IDLE the RAM looks at the live address so that a LATENCY=0 read
    // already has its data registered by the time RESP is reached.
    assign ram_addr = (state_q == IDLE) ? bus.addr : addr_q;

    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem_array (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        busy_d  = busy_q;
        err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.MemRead || bus.MemWrite) begin
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    if (bus.MemRead && bus.MemWrite) begin
                        op_d = OP_BAD;
                    end else if (bus.MemWrite) begin
                        op_d = OP_WR;
                    end else begin
                        op_d = OP_RD;
                    end
                    busy_d  = 1'b1;
                    cnt_d   = CntInit;
                    state_d = (LATENCY > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                ready_d = 1'b1;
                err_d   = bad_req;
                busy_d  = 1'b0;
                state_d = IDLE;
                // Reads (including the both-strobes case) update rdata; illegal ones zero it.
                if (op_q != OP_WR) begin
                    rdata_d = bad_req ? '0 : ram_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= OP_RD;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= 4'd0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: two responders (LATENCY=0 and LATENCY=2) driven with
// directed and random accesses, checked against a word-array model.
module tb_mem_responder;
    import mem_pkg::*;

    localparam int unsigned DEPTH = 200;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_responder_if #(.ADDR_W(8), .DATA_W(16)) b0 ();
    mem_responder_if #(.ADDR_W(8), .DATA_W(16)) b2 ();

    mem_responder #(.ADDR_W(8), .DATA_W(16), .DEPTH(DEPTH), .LATENCY(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    mem_responder #(.ADDR_W(8), .DATA_W(16), .DEPTH(DEPTH), .LATENCY(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (b2)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model: index 0 is the LATENCY=0 DUT, index 1 the LATENCY=2 DUT.
    logic [15:0] mdl [2][256];
    logic [15:0] m_rdata [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic drive(input int sel, input logic rd, input logic wr,
                         input logic [7:0] a, input logic [15:0] d);
        if (sel == 0) begin
            b0.MemRead = rd; b0.MemWrite = wr; b0.addr = a; b0.wdata = d;
        end else begin
            b2.MemRead = rd; b2.MemWrite = wr; b2.addr = a; b2.wdata = d;
        end
    endtask

    // {ready, busy, err, rdata}
    function automatic logic [18:0] outs(input int sel);
        if (sel == 0) return {b0.ready, b0.busy, b0.err, b0.rdata};
        return {b2.ready, b2.busy, b2.err, b2.rdata};
    endfunction

    // One complete access; chg re-drives a read of addr+1 during the wait.
    task automatic access(input int sel, input logic rd, input logic wr,
                          input logic [7:0] a, input logic [15:0] d, input bit chg);
        int          lat;
        bit          seen;
        bit          bad;
        logic [18:0] o;
        logic [15:0] exp_rd;
        lat = (sel == 0) ? 0 : 2;
        bad = (rd && wr) || (32'(a) >= DEPTH);
        exp_rd = m_rdata[sel];
        if (rd) exp_rd = bad ? 16'h0 : mdl[sel][a];
        m_rdata[sel] = exp_rd;
        if (wr && !bad) mdl[sel][a] = d;

        drive(sel, rd, wr, a, d);
        @(posedge clk);
        seen = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk);
            o = outs(sel);
            if (k == 1) begin
                if (chg) drive(sel, 1'b1, 1'b0, a + 8'd1, ~d);
                else drive(sel, 1'b0, 1'b0, a, d);
                check("busy_after_capture", {31'd0, o[17]}, 32'd1);
            end
            if (k == 2 && chg) drive(sel, 1'b0, 1'b0, a, d);
            if (o[18]) begin
                seen = 1'b1;
                check("ready_latency", k - 1, lat + 1);
                check("err", {31'd0, o[16]}, {31'd0, bad});
                check("busy_drop", {31'd0, o[17]}, 32'd0);
                check("rdata", {16'd0, o[15:0]}, {16'd0, exp_rd});
            end
        end
        if (!seen) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle_chk(input int sel, input int n);
        logic [18:0] o;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            o = outs(sel);
            check("idle_ready_low", {31'd0, o[18]}, 32'd0);
            check("idle_busy_low", {31'd0, o[17]}, 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [18:0] o;
        int          r;
        int          sel;
        logic [7:0]  a;

        drive(0, 1'b0, 1'b0, 8'h00, 16'h0000);
        drive(1, 1'b0, 1'b0, 8'h00, 16'h0000);
        #1 rst = 1'b1;
        #1;
        for (int s = 0; s < 2; s++) begin
            o = outs(s);
            check("reset_outputs", {13'd0, o}, 32'd0);
        end
        m_rdata[0] = 16'h0;
        m_rdata[1] = 16'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Give every in-range word a known value.
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < int'(DEPTH); i++)
                access(s, 1'b0, 1'b1, 8'(i), 16'($urandom), 1'b0);

        // Write then read, LATENCY=2; later write must not disturb rdata.
        access(1, 1'b0, 1'b1, 8'h10, 16'h1234, 1'b0);
        access(1, 1'b1, 1'b0, 8'h10, 16'h0000, 1'b0);
        check("l2_read_1234", {16'd0, b2.rdata}, 32'h1234);
        access(1, 1'b0, 1'b1, 8'h11, 16'h4321, 1'b0);
        check("rdata_hold", {16'd0, b2.rdata}, 32'h1234);
        idle_chk(1, 2);

        // LATENCY=0 read of a preloaded word, then a back-to-back read.
        access(0, 1'b0, 1'b1, 8'h05, 16'hBEEF, 1'b0);
        access(0, 1'b1, 1'b0, 8'h05, 16'h0000, 1'b0);
        check("l0_read_beef", {16'd0, b0.rdata}, 32'hBEEF);
        access(0, 1'b1, 1'b0, 8'h06, 16'h0000, 1'b0);
        idle_chk(0, 1);

        // Illegal requests.
        access(1, 1'b1, 1'b1, 8'h20, 16'h7777, 1'b0);
        check("both_strobes_rdata0", {16'd0, b2.rdata}, 32'h0);
        access(1, 1'b1, 1'b0, 8'h20, 16'h0000, 1'b0);
        access(0, 1'b1, 1'b1, 8'h20, 16'h7777, 1'b0);
        access(0, 1'b1, 1'b0, 8'h20, 16'h0000, 1'b0);
        access(1, 1'b0, 1'b1, 8'hC8, 16'h9999, 1'b0);
        access(1, 1'b1, 1'b0, 8'hC8, 16'h0000, 1'b0);
        access(1, 1'b1, 1'b0, 8'h48, 16'h0000, 1'b0);
        access(1, 1'b1, 1'b0, 8'h08, 16'h0000, 1'b0);

        // Strobe/address change during WAIT has no effect.
        access(1, 1'b0, 1'b1, 8'h30, 16'hAAAA, 1'b1);
        idle_chk(1, 4);
        access(1, 1'b1, 1'b0, 8'h30, 16'h0000, 1'b0);
        check("chg_addr30", {16'd0, b2.rdata}, 32'hAAAA);
        access(1, 1'b1, 1'b0, 8'h31, 16'h0000, 1'b0);

        // Reset mid-operation.
        access(1, 1'b0, 1'b1, 8'h40, 16'h0123, 1'b0);
        access(1, 1'b1, 1'b0, 8'h10, 16'h0000, 1'b0);
        drive(1, 1'b0, 1'b1, 8'h40, 16'h5555);
        @(posedge clk);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 8'h40, 16'h5555);
        check("busy_before_rst", {31'd0, b2.busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        o = outs(1);
        check("rst_mid_outputs", {13'd0, o}, 32'd0);
        m_rdata[0] = 16'h0;
        m_rdata[1] = 16'h0;
        @(negedge clk);
        rst = 1'b0;
        access(1, 1'b1, 1'b0, 8'h40, 16'h0000, 1'b0);
        check("rst_no_write", {16'd0, b2.rdata}, 32'h0123);

        // Random traffic.
        for (int i = 0; i < 200; i++) begin
            sel = int'($urandom_range(0, 1));
            r   = int'($urandom_range(0, 9));
            a   = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(200, 255))
                                              : 8'($urandom_range(0, 199));
            if (r == 0) access(sel, 1'b1, 1'b1, a, 16'($urandom), 1'b0);
            else if (r < 5) access(sel, 1'b0, 1'b1, a, 16'($urandom), 1'b0);
            else access(sel, 1'b1, 1'b0, a, 16'($urandom), 1'b0);
            idle_chk(sel, int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
